// File: rtl/reg_status_file.sv
// reg_status_file
// Architectural register file with per-register rename status (dirty bit and
// producing ROB tag). Read ports resolve operands combinationally, folding in
// a same-cycle rename, a same-cycle matching retire and a ROB lookup result.
//
// Ports
//   clk_in       system clock, state updates on posedge
//   rst_in       asynchronous active-high reset, clears all state
//   rdy_in       global stall; low freezes all state
//   flush_in     clears every dirty bit and tag, drops the same-cycle issue
//   commit_*     retire write of commit_data to commit_reg from commit_tag
//   issue_*      rename of issue_reg to ROB tag issue_tag
//   rd_id        NRD read indices, port k at [k*RID +: RID]
//   rd_val       per-port operand value (0 while pending)
//   rd_dep       per-port operand-pending flag
//   rd_tag       per-port producing tag (0 when not pending)
//   rob_q_tag    per-port ROB lookup tag (stored tag of the read register)
//   rob_q_ready  per-port ROB lookup hit, rob_q_val the looked-up value
//   dirty_count  registered number of dirty registers
module reg_status_file #(
    parameter int NREG    = 32,
    parameter int XLEN    = 32,
    parameter int ROB_BIT = 4,
    parameter int NRD     = 2,
    localparam int RID    = $clog2(NREG),
    localparam int CNT    = $clog2(NREG) + 1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   flush_in,
    input  logic                   commit_en,
    input  logic [RID-1:0]         commit_reg,
    input  logic [XLEN-1:0]        commit_data,
    input  logic [ROB_BIT-1:0]     commit_tag,
    input  logic                   issue_en,
    input  logic [RID-1:0]         issue_reg,
    input  logic [ROB_BIT-1:0]     issue_tag,
    input  logic [NRD*RID-1:0]     rd_id,
    output logic [NRD*XLEN-1:0]    rd_val,
    output logic [NRD-1:0]         rd_dep,
    output logic [NRD*ROB_BIT-1:0] rd_tag,
    output logic [NRD*ROB_BIT-1:0] rob_q_tag,
    input  logic [NRD-1:0]         rob_q_ready,
    input  logic [NRD*XLEN-1:0]    rob_q_val,
    output logic [CNT-1:0]         dirty_count
);

    logic [XLEN-1:0]    value_arr [NREG];
    logic [ROB_BIT-1:0] tag_arr   [NREG];
    logic [NREG-1:0]    dirty_vec;
    logic [NREG-1:0]    dirty_next_vec;
    logic [CNT-1:0]     count_next;
    logic [CNT-1:0]     dirty_count_reg;

    // Per-register state. Register 0 is a constant zero with no storage.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign value_arr[gi]      = '0;
                assign tag_arr[gi]        = '0;
                assign dirty_vec[gi]      = 1'b0;
                assign dirty_next_vec[gi] = 1'b0;
            end else begin : g_live
                logic [XLEN-1:0]    value_reg;
                logic               dirty_reg;
                logic               dirty_next;
                logic [ROB_BIT-1:0] tag_reg;
                logic [ROB_BIT-1:0] tag_next;
                logic               commit_hit;
                logic               issue_hit;

                assign commit_hit = commit_en && (commit_reg == RID'(gi));
                assign issue_hit  = issue_en && (issue_reg == RID'(gi));

                // Priority: flush clears everything, a rename beats a retire
                // of the same register, and a retire only clears status when
                // it comes from the tag currently owning the register.
                always_comb begin
                    dirty_next = dirty_reg;
                    tag_next   = tag_reg;
                    if (flush_in) begin
                        dirty_next = 1'b0;
                        tag_next   = '0;
                    end else if (issue_hit) begin
                        dirty_next = 1'b1;
                        tag_next   = issue_tag;
                    end else if (commit_hit && (tag_reg == commit_tag)) begin
                        dirty_next = 1'b0;
                        tag_next   = '0;
                    end
                end

                always_ff @(posedge clk_in or posedge rst_in) begin
                    if (rst_in) begin
                        value_reg <= '0;
                        dirty_reg <= 1'b0;
                        tag_reg   <= '0;
                    end else if (rdy_in) begin
                        // The value is written even on a stale-tag retire.
                        if (commit_hit) begin
                            value_reg <= commit_data;
                        end
                        dirty_reg <= dirty_next;
                        tag_reg   <= tag_next;
                    end
                end

                assign value_arr[gi]      = value_reg;
                assign tag_arr[gi]        = tag_reg;
                assign dirty_vec[gi]      = dirty_reg;
                assign dirty_next_vec[gi] = dirty_next;
            end
        end
    endgenerate

    // Count is taken from the next dirty vector so it lands together with
    // the update it describes.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < NREG; i++) begin
            count_next = count_next + CNT'(dirty_next_vec[i]);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dirty_count_reg <= '0;
        end else if (rdy_in) begin
            dirty_count_reg <= count_next;
        end
    end

    assign dirty_count = dirty_count_reg;

    // Read ports: zero-latency operand resolution.
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_port
            logic [RID-1:0]     rid;
            logic [XLEN-1:0]    val_c;
            logic               dep_c;
            logic [ROB_BIT-1:0] tag_c;

            assign rid = rd_id[gi*RID +: RID];

            always_comb begin
                val_c = '0;
                dep_c = 1'b0;
                tag_c = '0;
                if (rid == '0) begin
                    val_c = '0;
                end else if (issue_en && (issue_reg == rid)) begin
                    dep_c = 1'b1;
                    tag_c = issue_tag;
                end else if (dirty_vec[rid] && commit_en && (commit_reg == rid)
                             && (commit_tag == tag_arr[rid])) begin
                    val_c = commit_data;
                end else if (dirty_vec[rid] && rob_q_ready[gi]) begin
                    val_c = rob_q_val[gi*XLEN +: XLEN];
                end else if (dirty_vec[rid]) begin
                    dep_c = 1'b1;
                    tag_c = tag_arr[rid];
                end else begin
                    val_c = value_arr[rid];
                end
            end

            assign rd_val[gi*XLEN +: XLEN]       = val_c;
            assign rd_dep[gi]                    = dep_c;
            assign rd_tag[gi*ROB_BIT +: ROB_BIT] = tag_c;
            assign rob_q_tag[gi*ROB_BIT +: ROB_BIT] = tag_arr[rid];
        end
    endgenerate

endmodule

// File: tb/tb_reg_status_file.sv
module tb_reg_status_file;

    localparam int NREG = 32, XLEN = 32, ROB_BIT = 4, NRD = 2;
    localparam int RID = $clog2(NREG), CNT = $clog2(NREG) + 1;

    logic                   clk_in = 1'b0;
    logic                   rst_in;
    logic                   rdy_in;
    logic                   flush_in;
    logic                   commit_en;
    logic [RID-1:0]         commit_reg;
    logic [XLEN-1:0]        commit_data;
    logic [ROB_BIT-1:0]     commit_tag;
    logic                   issue_en;
    logic [RID-1:0]         issue_reg;
    logic [ROB_BIT-1:0]     issue_tag;
    logic [NRD*RID-1:0]     rd_id;
    logic [NRD*XLEN-1:0]    rd_val;
    logic [NRD-1:0]         rd_dep;
    logic [NRD*ROB_BIT-1:0] rd_tag;
    logic [NRD*ROB_BIT-1:0] rob_q_tag;
    logic [NRD-1:0]         rob_q_ready;
    logic [NRD*XLEN-1:0]    rob_q_val;
    logic [CNT-1:0]         dirty_count;

    int total_checks  = 0;
    int passed_checks = 0;
    int failed_checks = 0;

    always #5 clk_in = ~clk_in;

    reg_status_file #(.NREG(NREG), .XLEN(XLEN), .ROB_BIT(ROB_BIT), .NRD(NRD)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .commit_en(commit_en), .commit_reg(commit_reg), .commit_data(commit_data),
        .commit_tag(commit_tag), .issue_en(issue_en), .issue_reg(issue_reg),
        .issue_tag(issue_tag), .rd_id(rd_id), .rd_val(rd_val), .rd_dep(rd_dep),
        .rd_tag(rd_tag), .rob_q_tag(rob_q_tag), .rob_q_ready(rob_q_ready),
        .rob_q_val(rob_q_val), .dirty_count(dirty_count)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total_checks++;
        assert (obs === exp) begin
            passed_checks++;
            $display("check %s ok value=%0h", name, obs);
        end else begin
            failed_checks++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_rd(input int p0, input int p1);
        rd_id[0 +: RID]   = RID'(p0);
        rd_id[RID +: RID] = RID'(p1);
    endtask

    task automatic idle();
        commit_en = 1'b0; issue_en = 1'b0; flush_in = 1'b0; rob_q_ready = '0;
    endtask

    task automatic do_issue(input int r, input int t);
        issue_en = 1'b1; issue_reg = RID'(r); issue_tag = ROB_BIT'(t);
    endtask

    task automatic do_commit(input int r, input int t, input logic [XLEN-1:0] d);
        commit_en = 1'b1; commit_reg = RID'(r); commit_tag = ROB_BIT'(t); commit_data = d;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
        commit_en = 1'b0; commit_reg = '0; commit_data = '0; commit_tag = '0;
        issue_en = 1'b0; issue_reg = '0; issue_tag = '0;
        rd_id = '0; rob_q_ready = '0; rob_q_val = '0;
        set_rd(5, 7);
        #1;
        check("reset_count", 64'(dirty_count), 64'd0);
        check("reset_dep", 64'(rd_dep), 64'd0);
        check("reset_val0", 64'(rd_val[0 +: XLEN]), 64'd0);
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Issue x5 tag 3, read it back pending
        do_issue(5, 3);
        step(); idle(); #1;
        check("x5_dep", 64'(rd_dep[0]), 64'd1);
        check("x5_tag", 64'(rd_tag[0 +: ROB_BIT]), 64'd3);
        check("x5_robq_tag", 64'(rob_q_tag[0 +: ROB_BIT]), 64'd3);
        check("x5_count", 64'(dirty_count), 64'd1);
        // ROB lookup hit resolves the operand
        rob_q_ready = 2'b01; rob_q_val[0 +: XLEN] = 32'h1234; #1;
        check("x5_robhit_val", 64'(rd_val[0 +: XLEN]), 64'h1234);
        check("x5_robhit_dep", 64'(rd_dep[0]), 64'd0);
        check("x5_robhit_tag", 64'(rd_tag[0 +: ROB_BIT]), 64'd0);
        rob_q_ready = '0;
        do_commit(5, 3, 32'h0505);
        step(); idle(); #1;
        check("x5_commit_val", 64'(rd_val[0 +: XLEN]), 64'h0505);
        check("x5_commit_count", 64'(dirty_count), 64'd0);

        // Same-cycle rename bypass on port 1
        do_issue(7, 2); #1;
        check("x7_bypass_dep", 64'(rd_dep[1]), 64'd1);
        check("x7_bypass_tag", 64'(rd_tag[ROB_BIT +: ROB_BIT]), 64'd2);
        check("x7_bypass_val", 64'(rd_val[XLEN +: XLEN]), 64'd0);
        step(); idle();
        do_commit(7, 2, 32'hABCD);
        step(); idle(); #1;
        check("x7_commit_val", 64'(rd_val[XLEN +: XLEN]), 64'hABCD);
        check("x7_commit_dep", 64'(rd_dep[1]), 64'd0);
        check("x7_commit_count", 64'(dirty_count), 64'd0);

        // Stale retire: value updated, rename to tag 6 survives
        do_issue(4, 1); step(); idle();
        do_issue(4, 6); step(); idle();
        do_commit(4, 1, 32'h11); step(); idle();
        set_rd(4, 0); #1;
        check("x4_stale_dep", 64'(rd_dep[0]), 64'd1);
        check("x4_stale_tag", 64'(rd_tag[0 +: ROB_BIT]), 64'd6);
        check("x4_stale_count", 64'(dirty_count), 64'd1);

        // Same-cycle matching retire forwarded to the read port
        do_issue(9, 5); step(); idle();
        check("x9_count", 64'(dirty_count), 64'd2);
        set_rd(9, 4);
        do_commit(9, 5, 32'h55); #1;
        check("x9_fwd_val", 64'(rd_val[0 +: XLEN]), 64'h55);
        check("x9_fwd_dep", 64'(rd_dep[0]), 64'd0);
        check("x4_other_dep", 64'(rd_dep[1]), 64'd1);
        step(); idle(); #1;
        check("x9_after_val", 64'(rd_val[0 +: XLEN]), 64'h55);
        check("x9_after_count", 64'(dirty_count), 64'd1);

        // Register 0 ignores writes and renames
        set_rd(9, 0);
        do_issue(0, 7); do_commit(0, 7, 32'hFF); #1;
        check("x0_same_val", 64'(rd_val[XLEN +: XLEN]), 64'd0);
        check("x0_same_dep", 64'(rd_dep[1]), 64'd0);
        step(); idle(); #1;
        check("x0_after_val", 64'(rd_val[XLEN +: XLEN]), 64'd0);
        check("x0_after_count", 64'(dirty_count), 64'd1);

        // Commit and issue to the same register: issue wins the status
        do_issue(6, 2); step(); idle();
        do_commit(6, 2, 32'h66); do_issue(6, 4); step(); idle();
        set_rd(6, 0); #1;
        check("x6_ci_dep", 64'(rd_dep[0]), 64'd1);
        check("x6_ci_tag", 64'(rd_tag[0 +: ROB_BIT]), 64'd4);
        check("x6_ci_count", 64'(dirty_count), 64'd2);

        // Flush with three dirty registers, commit kept, issue dropped
        do_issue(10, 7); step(); idle();
        check("pre_flush_count", 64'(dirty_count), 64'd3);
        flush_in = 1'b1; do_commit(3, 0, 32'h77);
        step(); idle();
        do_issue(11, 1); flush_in = 1'b1; step(); idle();
        set_rd(3, 4); #1;
        check("flush_count", 64'(dirty_count), 64'd0);
        check("flush_x3_val", 64'(rd_val[0 +: XLEN]), 64'h77);
        check("flush_x4_val", 64'(rd_val[XLEN +: XLEN]), 64'h11);
        check("flush_dep", 64'(rd_dep), 64'd0);
        set_rd(6, 11); #1;
        check("flush_x6_val", 64'(rd_val[0 +: XLEN]), 64'h66);
        check("flush_x11_dep", 64'(rd_dep[1]), 64'd0);

        // Stall: three cycles of pulses with rdy_in low change nothing
        do_issue(12, 3); step(); idle();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_issue(13, 2); do_commit(12, 3, 32'h99); step();
        end
        idle(); rdy_in = 1'b1;
        set_rd(12, 13); #1;
        check("stall_count", 64'(dirty_count), 64'd1);
        check("stall_x12_dep", 64'(rd_dep[0]), 64'd1);
        check("stall_x12_tag", 64'(rd_tag[0 +: ROB_BIT]), 64'd3);
        check("stall_x13_dep", 64'(rd_dep[1]), 64'd0);

        // Asynchronous reset between edges
        #2 rst_in = 1'b1;
        #1;
        check("arst_count", 64'(dirty_count), 64'd0);
        check("arst_dep", 64'(rd_dep), 64'd0);
        set_rd(3, 6); #1;
        check("arst_x3_val", 64'(rd_val[0 +: XLEN]), 64'd0);
        check("arst_x6_val", 64'(rd_val[XLEN +: XLEN]), 64'd0);
        rst_in = 1'b0;

        // First edge after release works normally
        do_issue(2, 1); step(); idle();
        set_rd(2, 0); #1;
        check("post_rst_count", 64'(dirty_count), 64'd1);
        check("post_rst_dep", 64'(rd_dep[0]), 64'd1);
        check("post_rst_tag", 64'(rd_tag[0 +: ROB_BIT]), 64'd1);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
